// File: rtl/seq_divider_4bit_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Imported by the divider interface, step datapath and top.
package div_pkg;

  localparam int DEF_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/seq_divider_4bit_if.sv
// Start/done handshake bundle between a requester and the divider.
// The requester drives operands; the divider returns results.
interface seq_divider_4bit_if
  #(parameter int WIDTH = div_pkg::DEF_WIDTH) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_4bit_step.sv
// One shift-compare-subtract iteration of the restoring divider.
// Purely combinational so it can be exercised on its own.
module div_step #(
  parameter int WIDTH = div_pkg::DEF_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   d_ext;

  always_comb begin
    r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
    q_sh  = {q[WIDTH-2:0], 1'b0};
    d_ext = {1'b0, d};
    r_nxt = r_sh;
    q_nxt = q_sh;
    if (r_sh >= d_ext) begin
      r_nxt = r_sh - d_ext;
      q_nxt = q_sh | WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_divider_4bit.sv
// Sequential restoring divider: one quotient bit per clock,
// registered results with a single-cycle done pulse.
module seq_divider_4bit
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  seq_divider_4bit_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic             last;
  logic             d_zero;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r     (r),
    .q     (q),
    .d     (d),
    .r_nxt (r_nxt),
    .q_nxt (q_nxt)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign d_zero = (d == '0);

  // On a zero divisor CALC is skipped, so q still holds the dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start) begin
            q     <= bus.dividend;
            d     <= bus.divisor;
            r     <= '0;
            cnt   <= '0;
            state <= (bus.divisor == '0)
                     ? DONE : CALC;
          end
        end
        (state == CALC): begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (last) state <= DONE;
        end
        (state == DONE): begin
          done_r <= 1'b1;
          dbz_r  <= d_zero;
          quo_r  <= d_zero ? '1 : q;
          rem_r  <= d_zero ? q : r[WIDTH-1:0];
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// Scoreboard bench for seq_divider_4bit: issued ops push golden
// results; a monitor pops and compares on every done pulse.
module tb_seq_divider_4bit;

  localparam int W = 4;

  typedef struct {
    int q;
    int r;
    int z;
    int k;
    int lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   done_cnt;
  logic prev_done;
  exp_t sb[$];

  seq_divider_4bit_if #(.WIDTH(W)) dut_if ();

  seq_divider_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               name, act, exp, $time);
    end
  endfunction

  // Golden result from plain integer arithmetic.
  function automatic exp_t golden(int a, int b, int k);
    exp_t e;
    if (b == 0) begin
      e.q   = (1 << W) - 1;
      e.r   = a;
      e.z   = 1;
      e.lat = 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.z   = 0;
      e.lat = W + 1;
    end
    e.k = k;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && dut_if.done) begin
      done_cnt++;
      chk("done_pulse_width", int'(prev_done), 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done q=%0d r=%0d",
                 dut_if.quotient, dut_if.remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", int'(dut_if.quotient), e.q);
        chk("remainder", int'(dut_if.remainder), e.r);
        chk("div_by_zero", int'(dut_if.div_by_zero), e.z);
        chk("latency", cyc - e.k, e.lat);
      end
    end
    prev_done = dut_if.done;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (dut_if.busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (dut_if.busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout busy=1 want=0");
    end
  endtask

  task automatic issue(int a, int b);
    wait_idle();
    dut_if.start    = 1'b1;
    dut_if.dividend = W'(a);
    dut_if.divisor  = W'(b);
    @(posedge clk);
    #1;
    sb.push_back(golden(a, b, cyc));
    dut_if.start = 1'b0;
    chk("busy_after_start", int'(dut_if.busy), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int base;
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    done_cnt  = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    dut_if.start    = 1'b0;
    dut_if.dividend = '0;
    dut_if.divisor  = '0;
    #12;
    chk("rst_busy", int'(dut_if.busy), 0);
    chk("rst_done", int'(dut_if.done), 0);
    chk("rst_quotient", int'(dut_if.quotient), 0);
    chk("rst_remainder", int'(dut_if.remainder), 0);
    chk("rst_dbz", int'(dut_if.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(13, 3);
    issue(7, 0);
    issue(3, 9);
    issue(15, 1);
    drain();

    // A start during CALC must be dropped, not queued.
    issue(12, 5);
    dut_if.start    = 1'b1;
    dut_if.dividend = 4'd9;
    dut_if.divisor  = 4'd2;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    chk("quotient_held_calc",
        int'(dut_if.quotient), 15);
    drain();
    repeat (8) @(negedge clk);

    // Reset mid-operation aborts with no done.
    issue(14, 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", int'(dut_if.busy), 0);
    chk("abort_done", int'(dut_if.done), 0);
    chk("abort_quotient", int'(dut_if.quotient), 0);
    chk("abort_remainder", int'(dut_if.remainder), 0);
    chk("abort_dbz", int'(dut_if.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(10, 4);
    drain();

    base = done_cnt;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(a, b);
      end
    end
    drain();
    chk("sweep_done_count", done_cnt - base, 256);

    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(15, 0)),
            int'($urandom_range(15, 0)));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
